// File: rtl/periph_bus_pkg.sv
// Shared request/response bundle types for the peripheral-bus arbiter.
// The id field is sized for the widest supported master id.
package periph_bus_pkg;

    localparam int PB_ID_MAX = 32;

    typedef struct packed {
        logic [31:0]          add;
        logic                 wen;
        logic [31:0]          wdata;
        logic [3:0]           be;
        logic [PB_ID_MAX-1:0] id;
    } pb_req_t;

    typedef struct packed {
        logic [31:0]          rdata;
        logic                 opc;
        logic [PB_ID_MAX-1:0] id;
    } pb_rsp_t;

    function automatic int pb_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_tree_lite.sv
// Combinational round-robin pick: first eligible index at or after i_ptr,
// wrapping from N-1 back to 0.
module rr_arb_tree_lite #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_winner,
    output logic          o_valid
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap so non-power-of-2 N never relies on overflow
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N))
                w_sum = w_sum - (PW+1)'(N);
            w_idx = w_sum[PW-1:0];
            if (!o_valid && i_elig[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// N-to-1 round-robin peripheral-bus arbiter with one outstanding
// transaction per master and one-hot tagged slave responses.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int NB_MASTER = 4,
    parameter int ID_WIDTH  = 9
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_MASTER-1:0]               m_req_i,
    input  logic [NB_MASTER-1:0]               m_wen_i,
    input  logic [NB_MASTER-1:0][31:0]         m_add_i,
    input  logic [NB_MASTER-1:0][31:0]         m_wdata_i,
    input  logic [NB_MASTER-1:0][3:0]          m_be_i,
    input  logic [NB_MASTER-1:0][ID_WIDTH-1:0] m_id_i,
    output logic [NB_MASTER-1:0]               m_gnt_o,
    output logic [NB_MASTER-1:0]               m_r_valid_o,
    output logic [NB_MASTER-1:0]               m_r_opc_o,
    output logic [NB_MASTER-1:0][31:0]         m_r_rdata_o,
    output logic [NB_MASTER-1:0][ID_WIDTH-1:0] m_r_id_o,
    output logic                               s_req_o,
    output logic                               s_wen_o,
    output logic [31:0]                        s_add_o,
    output logic [31:0]                        s_wdata_o,
    output logic [3:0]                         s_be_o,
    output logic [NB_MASTER-1:0]               s_id_o,
    input  logic                               s_gnt_i,
    input  logic                               s_r_valid_i,
    input  logic                               s_r_opc_i,
    input  logic [31:0]                        s_r_rdata_i,
    input  logic [NB_MASTER-1:0]               s_r_id_i
);

    localparam int PW = pb_ptr_w(NB_MASTER);

    logic [PW-1:0]                     r_ptr;
    logic [NB_MASTER-1:0]              r_out;
    logic [NB_MASTER-1:0][ID_WIDTH-1:0] r_id;

    logic [PW-1:0]        w_winner;
    logic [PW-1:0]        w_ptr_nxt;
    logic [NB_MASTER-1:0] w_elig;
    logic [NB_MASTER-1:0] w_sel;
    logic [NB_MASTER-1:0] w_rsp_sel;
    logic                 w_valid;
    logic                 w_hs;
    logic                 w_rsp_ok;
    logic                 w_unused;
    pb_req_t              w_win;
    pb_rsp_t              w_rsp [NB_MASTER];

    assign w_elig = m_req_i & ~r_out;

    rr_arb_tree_lite #(
        .N  (NB_MASTER),
        .PW (PW)
    ) u_rr (
        .i_elig   (w_elig),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_sel = '0;
        w_win = '0;
        if (w_valid) begin
            w_sel[w_winner] = 1'b1;
            w_win.add       = m_add_i[w_winner];
            w_win.wen       = m_wen_i[w_winner];
            w_win.wdata     = m_wdata_i[w_winner];
            w_win.be        = m_be_i[w_winner];
            w_win.id        = PB_ID_MAX'(m_id_i[w_winner]);
        end
    end

    assign s_req_o   = w_valid;
    assign s_wen_o   = w_win.wen;
    assign s_add_o   = w_win.add;
    assign s_wdata_o = w_win.wdata;
    assign s_be_o    = w_win.be;
    assign s_id_o    = w_sel;
    assign m_gnt_o   = w_sel & {NB_MASTER{s_gnt_i}};
    assign w_hs      = w_valid & s_gnt_i;

    assign w_ptr_nxt = (w_winner == PW'(NB_MASTER - 1)) ?
                       '0 : w_winner + PW'(1);

    // stray responses (bad tag or nothing outstanding) are dropped
    assign w_rsp_ok  = s_r_valid_i && $onehot(s_r_id_i) &&
                       ((s_r_id_i & r_out) != '0);
    assign w_rsp_sel = w_rsp_ok ? s_r_id_i : '0;

    always_comb begin
        w_unused    = ^w_win.id;
        m_r_valid_o = w_rsp_sel;
        m_r_rdata_o = '0;
        m_r_opc_o   = '0;
        m_r_id_o    = '0;
        for (int k = 0; k < NB_MASTER; k++) begin
            w_rsp[k] = '0;
            if (w_rsp_sel[k]) begin
                w_rsp[k].rdata = s_r_rdata_i;
                w_rsp[k].opc   = s_r_opc_i;
                w_rsp[k].id    = PB_ID_MAX'(r_id[k]);
            end
            m_r_rdata_o[k] = w_rsp[k].rdata;
            m_r_opc_o[k]   = w_rsp[k].opc;
            m_r_id_o[k]    = w_rsp[k].id[ID_WIDTH-1:0];
            w_unused       = w_unused ^ (^w_rsp[k].id);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_out <= '0;
            r_id  <= '0;
        end else begin
            if (w_hs) begin
                r_ptr           <= w_ptr_nxt;
                r_id[w_winner]  <= m_id_i[w_winner];
            end
            r_out <= (r_out & ~w_rsp_sel) | (w_hs ? w_sel : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && s_r_valid_i)
            assert (w_rsp_ok)
            else $warning("periph_bus_arbiter: stray response dropped, id=%b",
                          s_r_id_i);
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: grants and responses are
// queued when driven and matched by a negedge monitor.
module tb_periph_bus_arbiter;

    localparam int NM = 4;
    localparam int IW = 9;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NM-1:0]         m_req_i, m_wen_i;
    logic [NM-1:0][31:0]   m_add_i, m_wdata_i;
    logic [NM-1:0][3:0]    m_be_i;
    logic [NM-1:0][IW-1:0] m_id_i;
    logic [NM-1:0]         m_gnt_o, m_r_valid_o, m_r_opc_o;
    logic [NM-1:0][31:0]   m_r_rdata_o;
    logic [NM-1:0][IW-1:0] m_r_id_o;
    logic                  s_req_o, s_wen_o;
    logic [31:0]           s_add_o, s_wdata_o;
    logic [3:0]            s_be_o;
    logic [NM-1:0]         s_id_o;
    logic                  s_gnt_i, s_r_valid_i, s_r_opc_i;
    logic [31:0]           s_r_rdata_i;
    logic [NM-1:0]         s_r_id_i;

    typedef struct {
        int            m;
        logic [31:0]   d;
        logic          opc;
        logic [IW-1:0] id;
    } rsp_t;

    int          gnt_q[$];
    rsp_t        rsp_q[$];
    logic [IW-1:0] mid [NM];
    logic [IW-1:0] gid [NM];
    int          n_chk = 0;
    int          n_err = 0;

    periph_bus_arbiter #(.NB_MASTER(NM), .ID_WIDTH(IW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_wen_i(m_wen_i),
        .m_add_i(m_add_i), .m_wdata_i(m_wdata_i),
        .m_be_i(m_be_i), .m_id_i(m_id_i),
        .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
        .m_r_opc_o(m_r_opc_o), .m_r_rdata_o(m_r_rdata_o),
        .m_r_id_o(m_r_id_o),
        .s_req_o(s_req_o), .s_wen_o(s_wen_o),
        .s_add_o(s_add_o), .s_wdata_o(s_wdata_o),
        .s_be_o(s_be_o), .s_id_o(s_id_o),
        .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i),
        .s_r_opc_i(s_r_opc_i), .s_r_rdata_i(s_r_rdata_i),
        .s_r_id_i(s_r_id_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < NM; k++) m_id_i[k] = mid[k];
    end

    function automatic logic [31:0] exp_add(input int m);
        return 32'h4000_0000 + 32'(m) * 32'd16;
    endfunction

    function automatic logic [31:0] exp_wdata(input int m);
        return 32'hC0DE_0000 + 32'(m);
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        int   m;
        rsp_t r;
        if (!rst_i) begin
            if (s_req_o && s_gnt_i) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 64'(s_id_o), 64'd0);
                end else begin
                    m = gnt_q.pop_front();
                    check("gnt_sid",   64'(s_id_o),    64'(1 << m));
                    check("gnt_mgnt",  64'(m_gnt_o),   64'(1 << m));
                    check("gnt_add",   64'(s_add_o),   64'(exp_add(m)));
                    check("gnt_wdata", 64'(s_wdata_o), 64'(exp_wdata(m)));
                    check("gnt_be",    64'(s_be_o),    64'(m + 1));
                    check("gnt_wen",   64'(s_wen_o),   64'(m % 2));
                end
            end else begin
                check("no_gnt", 64'(m_gnt_o), 64'd0);
            end
            for (int k = 0; k < NM; k++) begin
                if (m_r_valid_o[k]) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(m_r_valid_o[k]), 64'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_master", 64'(k), 64'(r.m));
                        check("rsp_rdata", 64'(m_r_rdata_o[k]), 64'(r.d));
                        check("rsp_opc", 64'(m_r_opc_o[k]), 64'(r.opc));
                        check("rsp_id", 64'(m_r_id_o[k]), 64'(r.id));
                    end
                end else begin
                    check("rsp_idle",
                          64'({m_r_rdata_o[k], m_r_opc_o[k], m_r_id_o[k]}),
                          64'd0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [NM-1:0] req, input logic gnt);
        m_req_i     = req;
        s_gnt_i     = gnt;
        s_r_valid_i = 1'b0;
        s_r_id_i    = '0;
        s_r_rdata_i = '0;
        s_r_opc_i   = 1'b0;
    endtask

    task automatic exp_gnt(input int m);
        gnt_q.push_back(m);
        gid[m] = mid[m];
    endtask

    task automatic resp(input int m, input logic [31:0] d, input logic opc);
        s_r_valid_i = 1'b1;
        s_r_id_i    = NM'(1 << m);
        s_r_rdata_i = d;
        s_r_opc_i   = opc;
        rsp_q.push_back('{m: m, d: d, opc: opc, id: gid[m]});
    endtask

    initial begin
        rst_i   = 1'b1;
        m_wen_i = 4'b1010;
        for (int k = 0; k < NM; k++) begin
            m_add_i[k]   = exp_add(k);
            m_wdata_i[k] = exp_wdata(k);
            m_be_i[k]    = 4'(k + 1);
            mid[k]       = 9'h100 + 9'(k * 7);
            gid[k]       = '0;
        end
        drive(4'b0000, 1'b0);
        #3;
        check("rst_sreq", 64'(s_req_o), 64'd0);
        check("rst_sid", 64'(s_id_o), 64'd0);
        check("rst_rvalid", 64'(m_r_valid_o), 64'd0);
        drive(4'b1000, 1'b1);
        #1;
        check("rst_comb_sid", 64'(s_id_o), 64'b1000);
        check("rst_comb_gnt", 64'(m_gnt_o), 64'b1000);
        cyc();
        cyc();
        rst_i = 1'b0;
        drive(4'b0000, 1'b0);
        cyc();

        // continuous requests, slave answers the cycle after each grant
        for (int c = 0; c < 6; c++) begin
            drive((c < 5) ? 4'b1111 : 4'b0000, c < 5);
            if (c == 4) mid[0] = 9'h0AA;
            if (c < 5) exp_gnt(c % 4);
            if (c > 0) resp((c - 1) % 4, 32'hA000_0000 + 32'(c), 1'(c));
            cyc();
        end

        // slave stalls three cycles: request and tag must hold
        for (int c = 0; c < 4; c++) begin
            drive(4'b0110, c == 3);
            if (c == 3) exp_gnt(1);
            #3;
            check("stall_sid", 64'(s_id_o), 64'b0010);
            if (c < 3) check("stall_gnt", 64'(m_gnt_o), 64'd0);
            cyc();
        end
        drive(4'b0000, 1'b0);
        resp(1, 32'h1111_2222, 1'b1);
        cyc();
        drive(4'b0110, 1'b0);
        #3;
        check("ptr_after_stall", 64'(s_id_o), 64'b0100);
        cyc();

        // id capture and delayed response
        mid[2] = 9'h1A5;
        drive(4'b0100, 1'b1);
        exp_gnt(2);
        cyc();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0100, 1'b0);
            #3;
            check("outstanding_blocked", 64'(s_req_o), 64'd0);
            cyc();
        end
        drive(4'b0000, 1'b0);
        resp(2, 32'hDEADBEEF, 1'b0);
        cyc();
        drive(4'b0100, 1'b0);
        #3;
        check("out2_cleared", 64'(s_id_o), 64'b0100);
        cyc();

        // master 0 outstanding keeps requesting; master 3 passes it
        drive(4'b0001, 1'b1);
        exp_gnt(0);
        cyc();
        drive(4'b1001, 1'b1);
        exp_gnt(3);
        cyc();
        drive(4'b1001, 1'b1);
        #3;
        check("m0_m3_blocked", 64'(s_req_o), 64'd0);
        cyc();
        drive(4'b0001, 1'b1);
        resp(0, 32'h0BAD_F00D, 1'b1);
        #3;
        check("m0_resp_cycle", 64'(s_req_o), 64'd0);
        cyc();
        drive(4'b0001, 1'b1);
        exp_gnt(0);
        cyc();
        drive(4'b0000, 1'b0);
        resp(3, 32'h3333_0003, 1'b0);
        cyc();
        drive(4'b0000, 1'b0);
        resp(0, 32'h0000_0C0C, 1'b0);
        cyc();

        // grant to 3 and response to 1 in the same cycle
        drive(4'b0010, 1'b1);
        exp_gnt(1);
        cyc();
        drive(4'b1000, 1'b1);
        exp_gnt(3);
        resp(1, 32'h5555_AAAA, 1'b1);
        cyc();
        drive(4'b1010, 1'b0);
        #3;
        check("concurrent_out", 64'(s_id_o), 64'b0010);
        cyc();

        // async reset with two transactions in flight
        drive(4'b0000, 1'b0);
        resp(3, 32'h6666_0006, 1'b0);
        cyc();
        drive(4'b0101, 1'b1);
        exp_gnt(0);
        cyc();
        drive(4'b0100, 1'b1);
        exp_gnt(2);
        cyc();
        drive(4'b0101, 1'b0);
        #1;
        check("pre_rst_blocked", 64'(s_req_o), 64'd0);
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_sid", 64'(s_id_o), 64'b0001);
        check("async_rst_req", 64'(s_req_o), 64'd1);
        cyc();
        rst_i = 1'b0;
        drive(4'b0000, 1'b0);
        s_r_valid_i = 1'b1;
        s_r_id_i    = 4'b0001;
        s_r_rdata_i = 32'hFFFF_FFFF;
        #3;
        check("stray_rvalid", 64'(m_r_valid_o), 64'd0);
        cyc();
        drive(4'b0000, 1'b0);
        cyc();

        check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
